// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an internal baud divider
// and a valid/ready input handshake. Frame: start, DATA_BITS data (LSB first),
// optional parity, STOP_BITS stop bits. All outputs except in_ready are registered.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (PARITY < 0 || PARITY > 2 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
            CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 ||
            DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_params
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state, w_state_n;
    logic [BAUD_W-1:0]     r_baud,  w_baud_n;
    logic [BIT_W-1:0]      r_bit,   w_bit_n;
    logic                  r_stop,  w_stop_n;
    logic [DATA_BITS-1:0]  r_shift, w_shift_n;
    logic                  r_par,   w_par_n;
    logic                  r_out,   w_out_n;
    logic                  r_busy,  w_busy_n;
    logic                  r_done,  w_done_n;
    logic                  w_bit_end;

    assign in_ready = (r_state == S_IDLE) && !rst;
    assign out      = r_out;
    assign busy     = r_busy;
    assign done     = r_done;

    // State register and registered datapath/outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_stop  <= w_stop_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_out   <= w_out_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    // Next-state, counters and next value of the registered line output
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud + 1'b1;
        w_bit_n   = r_bit;
        w_stop_n  = r_stop;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_bit_end = (r_baud == BAUD_LAST);

        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                w_busy_n = 1'b0;
                if (in_valid && in_ready) begin
                    w_state_n = S_START;
                    w_shift_n = in_data;
                    w_par_n   = (PARITY == 1) ? ~^in_data : ^in_data;
                    w_bit_n   = '0;
                    w_stop_n  = 1'b0;
                    w_busy_n  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n = S_DATA;
                    w_baud_n  = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_n = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_n   = r_bit + 1'b1;
                        w_shift_n = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_n = S_STOP;
                    w_baud_n  = '0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_n = '0;
                    if (r_stop == STOP_LAST) begin
                        w_state_n = S_IDLE;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                    end else begin
                        w_stop_n = r_stop + 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_baud_n  = '0;
                w_busy_n  = 1'b0;
            end
        endcase

        // Line level is decoded from the next state so out is registered
        // yet changes on the same edge as the state.
        case (w_state_n)
            S_START:  w_out_n = 1'b0;
            S_DATA:   w_out_n = w_shift_n[0];
            S_PARITY: w_out_n = w_par_n;
            default:  w_out_n = 1'b1;
        endcase
    end

endmodule
